// File: rtl/cut_eval_toggle_mon.sv
// Multi-channel registered evaluator of f = (a ^ b) & (a | c | d) with per-channel output toggle counting over fixed windows.
// Optional macro CUT_EVAL_IN_TOG_EN adds in_tog_cnt, a saturating count of input bit toggles per window.
module cut_eval_toggle_mon #(
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*CH-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH-1:0]         out_data,
  output logic                  win_done,
  output logic [CH*CNT_W-1:0]   tog_cnt
`ifdef CUT_EVAL_IN_TOG_EN
  ,
  output logic [CNT_W+1:0]      in_tog_cnt
`endif
);

  localparam int SC_W = $clog2(WIN_LEN + 1);

  typedef enum logic {FIRST, RUN} state_t;

  function automatic logic [CH-1:0] eval_cut(input logic [4*CH-1:0] w);
    logic [CH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      r[k] = (w[4*k] ^ w[4*k+1]) & (w[4*k] | w[4*k+2] | w[4*k+3]);
    end
    return r;
  endfunction

  logic                 accept, xfer, win_close;
  logic                 out_valid_q, out_valid_d;
  logic [CH-1:0]        out_data_q, out_data_d;
  logic [CH-1:0]        prev_q, prev_d;
  logic                 win_done_q, win_done_d;
  logic [CH*CNT_W-1:0]  tog_q, tog_d;
  logic [CNT_W-1:0]     live_q [CH];
  logic [CNT_W-1:0]     live_d [CH];
  logic [SC_W-1:0]      samp_q, samp_d;
  state_t               state_q, state_d;
`ifdef CUT_EVAL_IN_TOG_EN
  localparam logic [CNT_W+1:0] IN_MAX = '1;
  logic [CNT_W+1:0]     in_live_q, in_live_d;
  logic [CNT_W+1:0]     in_tog_q, in_tog_d;
  logic [4*CH-1:0]      prev_in_q, prev_in_d;
  logic                 have_in_q, have_in_d;
  logic [8:0]           pop;
  logic [CNT_W+10:0]    in_sum;
`endif

  assign in_ready = ~out_valid_q | out_ready;

  always_comb begin
    accept      = in_valid & in_ready;
    xfer        = out_valid_q & out_ready;
    win_close   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prev_d      = prev_q;
    win_done_d  = 1'b0;
    tog_d       = tog_q;
    live_d      = live_q;
    samp_d      = samp_q;
    state_d     = state_q;

    if (accept) begin
      out_data_d  = eval_cut(in_data);
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    // clr overrides the counting side of a coincident transfer only
    if (clr) begin
      for (int k = 0; k < CH; k++) live_d[k] = '0;
      samp_d  = '0;
      state_d = FIRST;
    end else if (xfer) begin
      prev_d = out_data_q;
      if (state_q == FIRST) begin
        samp_d  = SC_W'(1);
        state_d = RUN;
      end else begin
        for (int k = 0; k < CH; k++) begin
          if ((out_data_q[k] != prev_q[k]) && (live_q[k] != '1)) begin
            live_d[k] = live_q[k] + 1'b1;
          end
        end
        if (samp_q == SC_W'(WIN_LEN - 1)) win_close = 1'b1;
        else samp_d = samp_q + 1'b1;
      end
    end

`ifdef CUT_EVAL_IN_TOG_EN
    in_live_d = in_live_q;
    in_tog_d  = in_tog_q;
    prev_in_d = prev_in_q;
    have_in_d = have_in_q;
    pop       = 9'($countones(in_data ^ prev_in_q));
    in_sum    = {9'd0, in_live_q} + {{(CNT_W+2){1'b0}}, pop};
    if (clr) begin
      in_live_d = '0;
      have_in_d = 1'b0;
    end
    if (accept) begin
      if (have_in_q && !clr) begin
        in_live_d = (in_sum > {9'd0, IN_MAX}) ? IN_MAX : in_sum[CNT_W+1:0];
      end
      prev_in_d = in_data;
      have_in_d = 1'b1;
    end
`endif

    if (win_close) begin
      for (int k = 0; k < CH; k++) begin
        tog_d[k*CNT_W +: CNT_W] = live_d[k];
        live_d[k] = '0;
      end
      samp_d     = '0;
      win_done_d = 1'b1;
`ifdef CUT_EVAL_IN_TOG_EN
      in_tog_d  = in_live_d;
      in_live_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prev_q      <= '0;
      win_done_q  <= 1'b0;
      tog_q       <= '0;
      for (int k = 0; k < CH; k++) live_q[k] <= '0;
      samp_q      <= '0;
      state_q     <= FIRST;
`ifdef CUT_EVAL_IN_TOG_EN
      in_live_q   <= '0;
      in_tog_q    <= '0;
      prev_in_q   <= '0;
      have_in_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prev_q      <= prev_d;
      win_done_q  <= win_done_d;
      tog_q       <= tog_d;
      for (int k = 0; k < CH; k++) live_q[k] <= live_d[k];
      samp_q      <= samp_d;
      state_q     <= state_d;
`ifdef CUT_EVAL_IN_TOG_EN
      in_live_q   <= in_live_d;
      in_tog_q    <= in_tog_d;
      prev_in_q   <= prev_in_d;
      have_in_q   <= have_in_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_done  = win_done_q;
  assign tog_cnt   = tog_q;
`ifdef CUT_EVAL_IN_TOG_EN
  assign in_tog_cnt = in_tog_q;
`endif

endmodule
